// File: rtl/serializer_if.sv
`default_nettype none
// ============================================================================
// Module   : serializer_if
// Purpose  : Word-side handshake and serial-side outputs of the serializer.
// Revision : 1.0
// ============================================================================
interface serializer_if #(
    parameter int DATA_BUS_WIDTH = 16,
    parameter int MOD_WIDTH      = $clog2(DATA_BUS_WIDTH)
);
    logic [DATA_BUS_WIDTH-1:0] data_i;
    logic [MOD_WIDTH-1:0]      data_mod_i;
    logic                      data_val_i;
    logic                      ready_o;
    logic                      ser_data_o;
    logic                      ser_data_val_o;
    logic                      busy_o;

    modport master (
        output data_i,
        output data_mod_i,
        output data_val_i,
        input  ready_o,
        input  ser_data_o,
        input  ser_data_val_o,
        input  busy_o
    );

    modport slave (
        input  data_i,
        input  data_mod_i,
        input  data_val_i,
        output ready_o,
        output ser_data_o,
        output ser_data_val_o,
        output busy_o
    );
endinterface
`default_nettype wire

// File: rtl/serializer.sv
`default_nettype none
// ============================================================================
// Module   : serializer
// Purpose  : Parallel-to-serial transmitter, MSB first, one-word pending slot.
// Revision : 1.0
// ============================================================================
module serializer #(
    parameter int DATA_BUS_WIDTH = 16,
    parameter int MOD_WIDTH      = $clog2(DATA_BUS_WIDTH)
) (
    input  logic         clk_i,
    input  logic         srst_i,
    serializer_if.slave  bus
);
    localparam int CNT_W = MOD_WIDTH + 1;

    localparam logic [0:0] S_IDLE  = 1'b0;
    localparam logic [0:0] S_SHIFT = 1'b1;

    logic [0:0]                r_state;
    logic [DATA_BUS_WIDTH-1:0] r_shift;
    logic [CNT_W-1:0]          r_cnt;
    logic [DATA_BUS_WIDTH-1:0] r_pend_data;
    logic [CNT_W-1:0]          r_pend_n;
    logic                      r_pend_val;
    logic                      r_ser_data;
    logic                      r_ser_val;

    logic                      w_ready;
    logic                      w_accept;
    logic                      w_last;
    logic                      w_to_pend;
    logic                      w_load;
    logic [DATA_BUS_WIDTH-1:0] w_load_data;
    logic [CNT_W-1:0]          w_load_n;
    logic [CNT_W-1:0]          w_in_n;

    assign w_ready   = !r_pend_val && !srst_i;
    assign w_accept  = bus.data_val_i && w_ready;
    assign w_in_n    = (bus.data_mod_i == '0) ? CNT_W'(DATA_BUS_WIDTH)
                                              : {1'b0, bus.data_mod_i};
    // r_cnt counts bits of the current word still owed, including the one on the wire
    assign w_last    = (r_state == S_SHIFT) && (r_cnt == CNT_W'(1));
    assign w_to_pend = w_accept && (r_state == S_SHIFT) && !w_last;

    always_comb begin
        w_load      = 1'b0;
        w_load_data = bus.data_i;
        w_load_n    = w_in_n;
        if (r_state == S_IDLE) begin
            w_load = w_accept;
        end else if (w_last) begin
            if (r_pend_val) begin
                w_load      = 1'b1;
                w_load_data = r_pend_data;
                w_load_n    = r_pend_n;
            end else begin
                w_load = w_accept;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            r_state     <= S_IDLE;
            r_shift     <= '0;
            r_cnt       <= '0;
            r_pend_data <= '0;
            r_pend_n    <= '0;
            r_pend_val  <= 1'b0;
            r_ser_data  <= 1'b0;
            r_ser_val   <= 1'b0;
        end else begin
            if (w_load) begin
                r_state    <= S_SHIFT;
                r_ser_data <= w_load_data[DATA_BUS_WIDTH-1];
                r_ser_val  <= 1'b1;
                r_shift    <= {w_load_data[DATA_BUS_WIDTH-2:0], 1'b0};
                r_cnt      <= w_load_n;
            end else if ((r_state == S_SHIFT) && !w_last) begin
                r_ser_data <= r_shift[DATA_BUS_WIDTH-1];
                r_shift    <= {r_shift[DATA_BUS_WIDTH-2:0], 1'b0};
                r_cnt      <= r_cnt - CNT_W'(1);
            end else begin
                r_state    <= S_IDLE;
                r_ser_data <= 1'b0;
                r_ser_val  <= 1'b0;
                r_cnt      <= '0;
            end

            if (w_to_pend) begin
                r_pend_val  <= 1'b1;
                r_pend_data <= bus.data_i;
                r_pend_n    <= w_in_n;
            end else if (w_last && r_pend_val) begin
                r_pend_val  <= 1'b0;
            end
        end
    end

    assign bus.ready_o        = w_ready;
    assign bus.ser_data_o     = r_ser_data;
    assign bus.ser_data_val_o = r_ser_val;
    assign bus.busy_o         = (r_state == S_SHIFT) || r_pend_val;

endmodule
`default_nettype wire
